// File: rtl/operand_fetch_stage_if.sv
// Handshake bundle between decode, the operand fetch stage and EX.
//   in_*  : decoded instruction offered by decode (in_valid/in_ready)
//   out_* : resolved instruction held for EX (out_valid/out_ready)
// master = the decode/EX environment, slave = operand_fetch_stage.
interface operand_fetch_stage_if #(
  parameter int CTRL_W = 8
);
  // decode -> stage
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [4:0]        in_rd;
  logic [31:0]       in_imm;
  logic              in_use_imm;
  logic              in_is_load;
  logic [CTRL_W-1:0] in_ctrl;
  // stage -> EX
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_op_a;
  logic [31:0]       out_op_b;
  logic [31:0]       out_store_data;
  logic [4:0]        out_rd;
  logic              out_is_load;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_imm, in_use_imm, in_is_load, in_ctrl,
    input  in_ready,
    input  out_valid, out_op_a, out_op_b, out_store_data, out_rd, out_is_load, out_ctrl,
    output out_ready
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_imm, in_use_imm, in_is_load, in_ctrl,
    output in_ready,
    output out_valid, out_op_a, out_op_b, out_store_data, out_rd, out_is_load, out_ctrl,
    input  out_ready
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: sits in front of the 32x32 register file.
//   clk, reset      : clock, synchronous active-high reset
//   flush           : branch redirect, kills the held instruction and the load interlock
//   bus (slave)     : decode-side in_* handshake and EX-side out_* handshake
//   rf_read_addr1/2 : combinational read addresses (= in_rs1 / in_rs2)
//   rf_read_data1/2 : register file read data
//   ex_fwd_*        : EX result bypass (never a load)
//   wb_fwd_*        : writeback bypass, identical to the file write port
// Register 31 reads as zero regardless of file contents or bypass traffic.

// Per-source resolution: value with bypass priority, plus load-use hazard.
module operand_resolve (
  input  logic [4:0]  src,
  input  logic [31:0] rf_data,
  input  logic        ex_valid,
  input  logic [4:0]  ex_addr,
  input  logic [31:0] ex_data,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        ld_out_vld,   // a load is sitting in the output register
  input  logic [4:0]  ld_out_rd,
  input  logic        ld_pend_vld,  // a load left and its data is not yet on WB
  input  logic [4:0]  ld_pend_rd,
  output logic [31:0] value,
  output logic        hazard
);
  localparam logic [4:0] ZERO_REG = 5'd31;

  always_comb begin
    value = rf_data;
    // EX is younger than WB, so it wins when both target the same register.
    // WB must be bypassed: the file only shows the write on the next cycle.
    if (src == ZERO_REG)                  value = '0;
    else if (ex_valid && ex_addr == src)  value = ex_data;
    else if (wb_valid && wb_addr == src)  value = wb_data;
  end

  // A load targeting r31 produces nothing worth waiting for.
  assign hazard = (src != ZERO_REG) &&
                  ((ld_out_vld  && src == ld_out_rd) ||
                   (ld_pend_vld && src == ld_pend_rd));
endmodule

module operand_fetch_stage #(
  parameter int CTRL_W   = 8,
  parameter int LOAD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  operand_fetch_stage_if.slave bus,
  output logic [4:0]           rf_read_addr1,
  output logic [4:0]           rf_read_addr2,
  input  logic [31:0]          rf_read_data1,
  input  logic [31:0]          rf_read_data2,
  input  logic                 ex_fwd_valid,
  input  logic [4:0]           ex_fwd_addr,
  input  logic [31:0]          ex_fwd_data,
  input  logic                 wb_fwd_valid,
  input  logic [4:0]           wb_fwd_addr,
  input  logic [31:0]          wb_fwd_data
);
  localparam int         NUM_SRC  = 2;
  localparam int         CNT_W    = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [31:0]       op_a;
    logic [31:0]       op_b;
    logic [31:0]       store_data;
    logic [4:0]        rd;
    logic              is_load;
    logic [CTRL_W-1:0] ctrl;
  } ex_req_t;

  localparam ex_req_t EX_REQ_RST = '{
    op_a: '0, op_b: '0, store_data: '0, rd: ZERO_REG, is_load: 1'b0, ctrl: '0
  };

  ex_req_t          out_q;
  ex_req_t          nxt;
  logic             out_valid_q;
  logic [CNT_W-1:0] load_cnt;
  logic [4:0]       pend_rd;

  logic [NUM_SRC-1:0][4:0]  src;
  logic [NUM_SRC-1:0][31:0] rf_data;
  logic [NUM_SRC-1:0][31:0] res;
  logic [NUM_SRC-1:0]       src_haz;

  logic hazard;
  logic accept;
  logic handoff;

  assign rf_read_addr1 = bus.in_rs1;
  assign rf_read_addr2 = bus.in_rs2;

  assign src     = {bus.in_rs2, bus.in_rs1};
  assign rf_data = {rf_read_data2, rf_read_data1};

  // Both sources go through the same resolver; rs2 is checked for hazards
  // even when the immediate replaces it, because store_data still needs it.
  generate
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      operand_resolve u_res (
        .src         (src[g]),
        .rf_data     (rf_data[g]),
        .ex_valid    (ex_fwd_valid),
        .ex_addr     (ex_fwd_addr),
        .ex_data     (ex_fwd_data),
        .wb_valid    (wb_fwd_valid),
        .wb_addr     (wb_fwd_addr),
        .wb_data     (wb_fwd_data),
        .ld_out_vld  (out_valid_q && out_q.is_load),
        .ld_out_rd   (out_q.rd),
        .ld_pend_vld (load_cnt != '0),
        .ld_pend_rd  (pend_rd),
        .value       (res[g]),
        .hazard      (src_haz[g])
      );
    end
  endgenerate

  assign hazard       = bus.in_valid && (|src_haz);
  assign bus.in_ready = (!out_valid_q || bus.out_ready) && !hazard && !flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign handoff      = out_valid_q && bus.out_ready;

  always_comb begin
    nxt            = out_q;
    nxt.op_a       = res[0];
    nxt.op_b       = bus.in_use_imm ? bus.in_imm : res[1];
    nxt.store_data = res[1];
    nxt.rd         = bus.in_rd;
    nxt.is_load    = bus.in_is_load;
    nxt.ctrl       = bus.in_ctrl;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= EX_REQ_RST;
      out_valid_q <= 1'b0;
      load_cnt    <= '0;
      pend_rd     <= ZERO_REG;
    end else if (flush) begin
      // Any handshake this cycle is void; payload registers keep their values.
      out_valid_q <= 1'b0;
      load_cnt    <= '0;
    end else begin
      // Accept covers the back-to-back replace case as well.
      if (accept) begin
        out_q       <= nxt;
        out_valid_q <= 1'b1;
      end else if (handoff) begin
        out_valid_q <= 1'b0;
      end
      // The departing load keeps blocking consumers until its data reaches WB.
      if (handoff && out_q.is_load) begin
        load_cnt <= CNT_W'(LOAD_LAT);
        pend_rd  <= out_q.rd;
      end else if (load_cnt != '0) begin
        load_cnt <= load_cnt - CNT_W'(1);
      end
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_op_a       = out_q.op_a;
  assign bus.out_op_b       = out_q.op_b;
  assign bus.out_store_data = out_q.store_data;
  assign bus.out_rd         = out_q.rd;
  assign bus.out_is_load    = out_q.is_load;
  assign bus.out_ctrl       = out_q.ctrl;
endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;
  logic clk = 1'b0;
  logic reset, flush;
  always #5 clk = ~clk;

  operand_fetch_stage_if #(.CTRL_W(8)) bus ();

  logic [4:0]  rf_read_addr1, rf_read_addr2;
  logic [31:0] rf_read_data1, rf_read_data2;
  logic        ex_fwd_valid, wb_fwd_valid;
  logic [4:0]  ex_fwd_addr, wb_fwd_addr;
  logic [31:0] ex_fwd_data, wb_fwd_data;
  logic [31:0] rf [32];

  assign rf_read_data1 = rf[rf_read_addr1];
  assign rf_read_data2 = rf[rf_read_addr2];

  operand_fetch_stage #(.CTRL_W(8), .LOAD_LAT(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .bus           (bus),
    .rf_read_addr1 (rf_read_addr1),
    .rf_read_addr2 (rf_read_addr2),
    .rf_read_data1 (rf_read_data1),
    .rf_read_data2 (rf_read_data2),
    .ex_fwd_valid  (ex_fwd_valid),
    .ex_fwd_addr   (ex_fwd_addr),
    .ex_fwd_data   (ex_fwd_data),
    .wb_fwd_valid  (wb_fwd_valid),
    .wb_fwd_addr   (wb_fwd_addr),
    .wb_fwd_data   (wb_fwd_data)
  );

  typedef struct {
    logic [31:0] a, b, sd;
    logic [4:0]  rd;
    logic        ld;
    logic [7:0]  ctrl;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc;
  logic ok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every EX hand-off is compared with the oldest expectation.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else if (bus.out_valid && flush) begin
      if (q.size() > 0) void'(q.pop_front());
    end else if (bus.out_valid && bus.out_ready) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL xfer: got unexpected hand-off rd=%0d want none", bus.out_rd);
      end else begin
        mon_e = q.pop_front();
        if (bus.out_op_a !== mon_e.a || bus.out_op_b !== mon_e.b ||
            bus.out_store_data !== mon_e.sd || bus.out_rd !== mon_e.rd ||
            bus.out_is_load !== mon_e.ld || bus.out_ctrl !== mon_e.ctrl) begin
          n_err++;
          $display("FAIL xfer: got a=%h b=%h sd=%h rd=%0d ld=%0b ctrl=%h want a=%h b=%h sd=%h rd=%0d ld=%0b ctrl=%h",
                   bus.out_op_a, bus.out_op_b, bus.out_store_data, bus.out_rd, bus.out_is_load,
                   bus.out_ctrl, mon_e.a, mon_e.b, mon_e.sd, mon_e.rd, mon_e.ld, mon_e.ctrl);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] imm, input logic use_imm, input logic is_load,
                        input logic [7:0] ctrl);
    bus.in_valid   = 1'b1;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_rd      = rd;
    bus.in_imm     = imm;
    bus.in_use_imm = use_imm;
    bus.in_is_load = is_load;
    bus.in_ctrl    = ctrl;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                      input logic [4:0] rd, input logic ld, input logic [7:0] ctrl);
    exp_t e;
    e.a = a; e.b = b; e.sd = sd; e.rd = rd; e.ld = ld; e.ctrl = ctrl;
    q.push_back(e);
  endtask

  // Leaves the caller at the negedge of the cycle in which in_ready is high.
  task automatic wait_ready(input string name, input int maxc, output int c, output logic got);
    c = 0;
    @(negedge clk);
    while (!bus.in_ready && c < maxc) begin
      step();
      c++;
      @(negedge clk);
    end
    got = bus.in_ready;
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL %s: got in_ready=0 after %0d cycles want 1", name, c);
    end
  endtask

  task automatic issue(input string name, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] imm, input logic use_imm,
                       input logic is_load, input logic [7:0] ctrl,
                       input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] esd);
    int   c;
    logic g;
    set_in(rs1, rs2, rd, imm, use_imm, is_load, ctrl);
    wait_ready(name, 20, c, g);
    if (g) push(ea, eb, esd, rd, is_load, ctrl);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[1] = 32'd3; rf[2] = 32'd2; rf[4] = 32'hBAD; rf[5] = 32'h55; rf[7] = 32'h70;
    rf[10] = 32'hA0A0; rf[11] = 32'hB0B0; rf[31] = 32'hDEAD;
    reset = 1'b1; flush = 1'b0;
    ex_fwd_valid = 0; ex_fwd_addr = 0; ex_fwd_data = 0;
    wb_fwd_valid = 0; wb_fwd_addr = 0; wb_fwd_data = 0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_op_a", bus.out_op_a, 0);
    chk("rst_op_b", bus.out_op_b, 0);
    chk("rst_sd", bus.out_store_data, 0);
    chk("rst_rd", 32'(bus.out_rd), 31);
    chk("rst_ld", 32'(bus.out_is_load), 0);
    chk("rst_ctrl", 32'(bus.out_ctrl), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    step();
    reset = 1'b0;
    step();

    // Basic fetch, then immediate select
    issue("t1_basic", 1, 2, 3, 0, 0, 0, 8'h11, 3, 2, 2);
    @(negedge clk);
    chk("t1_latency", 32'(bus.out_valid), 1);
    step();
    issue("t1_imm", 1, 2, 3, 32'hFFFF_FFFB, 1, 0, 8'h12, 3, 32'hFFFF_FFFB, 2);

    // r31 reads zero; EX beats WB on the same register
    ex_fwd_valid = 1; ex_fwd_addr = 5; ex_fwd_data = 7;
    wb_fwd_valid = 1; wb_fwd_addr = 5; wb_fwd_data = 9;
    issue("t2_ex_prio", 31, 5, 3, 0, 0, 0, 8'h21, 0, 7, 7);
    ex_fwd_valid = 0;
    issue("t2_wb_only", 31, 5, 3, 0, 0, 0, 8'h22, 0, 9, 9);
    wb_fwd_valid = 0;
    ex_fwd_valid = 1; ex_fwd_addr = 31; ex_fwd_data = 32'h77;
    issue("t2_ex_r31", 31, 5, 3, 0, 0, 0, 8'h23, 0, 32'h55, 32'h55);
    ex_fwd_valid = 0;
    drain();

    // Load-use on rs1: three stall cycles, then WB data bypassed
    issue("t3_load", 1, 2, 4, 8, 1, 1, 8'h31, 3, 8, 2);
    set_in(4, 2, 6, 0, 0, 0, 8'h32);
    @(negedge clk); chk("t3_stall0", 32'(bus.in_ready), 0); step();
    @(negedge clk); chk("t3_stall1", 32'(bus.in_ready), 0); step();
    @(negedge clk); chk("t3_stall2", 32'(bus.in_ready), 0); step();
    wb_fwd_valid = 1; wb_fwd_addr = 4; wb_fwd_data = 32'h1234;
    @(negedge clk); chk("t3_go", 32'(bus.in_ready), 1);
    push(32'h1234, 2, 2, 6, 0, 8'h32);
    step();
    bus.in_valid = 0; wb_fwd_valid = 0;
    drain();

    // Load-use on rs2 while the immediate is selected
    issue("t3b_load", 1, 2, 7, 0, 0, 1, 8'h33, 3, 2, 2);
    set_in(1, 7, 12, 4, 1, 0, 8'h34);
    @(negedge clk); chk("t3b_stall", 32'(bus.in_ready), 0); step();
    wait_ready("t3b_wait", 10, cyc, ok);
    chk("t3b_stall_cnt", 32'(cyc), 2);
    if (ok) push(3, 4, 32'h70, 12, 0, 8'h34);
    step();
    bus.in_valid = 0;
    drain();

    // Load to r31 never stalls, replaced back-to-back
    issue("t3c_load31", 1, 2, 31, 0, 0, 1, 8'h35, 3, 2, 2);
    set_in(31, 31, 13, 0, 0, 0, 8'h36);
    @(negedge clk); chk("t3c_nostall", 32'(bus.in_ready), 1);
    push(0, 0, 0, 13, 0, 8'h36);
    step();
    bus.in_valid = 0;
    drain();

    // Backpressure hold, then one transfer per cycle
    bus.out_ready = 0;
    issue("t4_a", 1, 2, 8, 0, 0, 0, 8'h40, 3, 2, 2);
    set_in(2, 1, 9, 0, 0, 0, 8'h41);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_rdy", 32'(bus.in_ready), 0);
      chk("t4_hold_valid", 32'(bus.out_valid), 1);
      chk("t4_hold_op_a", bus.out_op_a, 3);
      chk("t4_hold_ctrl", 32'(bus.out_ctrl), 32'h40);
      step();
    end
    bus.out_ready = 1;
    @(negedge clk); chk("t4_b_rdy", 32'(bus.in_ready), 1);
    push(2, 3, 3, 9, 0, 8'h41); step();
    set_in(5, 1, 10, 0, 0, 0, 8'h42);
    @(negedge clk); chk("t4_c_rdy", 32'(bus.in_ready), 1);
    push(32'h55, 3, 3, 10, 0, 8'h42); step();
    set_in(2, 2, 11, 32'h100, 1, 0, 8'h43);
    @(negedge clk); chk("t4_d_rdy", 32'(bus.in_ready), 1);
    push(2, 32'h100, 2, 11, 0, 8'h43); step();
    bus.in_valid = 0;
    drain();

    // Flush while held
    bus.out_ready = 0;
    issue("t5_e", 1, 1, 14, 0, 0, 0, 8'h50, 3, 3, 3);
    set_in(2, 2, 15, 0, 0, 0, 8'h51);
    flush = 1;
    @(negedge clk); chk("t5_flush_rdy", 32'(bus.in_ready), 0);
    step();
    flush = 0;
    @(negedge clk);
    chk("t5_flush_valid", 32'(bus.out_valid), 0);
    chk("t5_next_rdy", 32'(bus.in_ready), 1);
    push(2, 2, 2, 15, 0, 8'h51);
    step();
    bus.in_valid = 0;
    drain();

    // Flush while interlocked
    issue("t5_g_load", 1, 2, 10, 0, 0, 1, 8'h52, 3, 2, 2);
    set_in(10, 1, 16, 0, 0, 0, 8'h53);
    @(negedge clk); chk("t5_il_stall0", 32'(bus.in_ready), 0); step();
    flush = 1;
    @(negedge clk); chk("t5_il_stall1", 32'(bus.in_ready), 0); step();
    flush = 0;
    @(negedge clk); chk("t5_il_go", 32'(bus.in_ready), 1);
    push(32'hA0A0, 3, 3, 16, 0, 8'h53);
    step();
    bus.in_valid = 0;
    drain();

    // Reset mid-stall
    issue("t6_j_load", 2, 1, 11, 0, 0, 1, 8'h66, 2, 3, 3);
    set_in(11, 1, 17, 0, 0, 0, 8'h67);
    @(negedge clk); chk("t6_stall", 32'(bus.in_ready), 0); step();
    bus.in_valid = 0;
    reset = 1;
    step();
    reset = 0;
    @(negedge clk);
    chk("t6_valid", 32'(bus.out_valid), 0);
    chk("t6_op_a", bus.out_op_a, 0);
    chk("t6_op_b", bus.out_op_b, 0);
    chk("t6_sd", bus.out_store_data, 0);
    chk("t6_rd", 32'(bus.out_rd), 31);
    chk("t6_ld", 32'(bus.out_is_load), 0);
    chk("t6_ctrl", 32'(bus.out_ctrl), 0);
    step();
    set_in(11, 1, 17, 0, 0, 0, 8'h67);
    @(negedge clk); chk("t6_after_rdy", 32'(bus.in_ready), 1);
    push(32'hB0B0, 3, 3, 17, 0, 8'h67);
    step();
    bus.in_valid = 0;
    drain();

    chk("sb_empty", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
